updown_counter: RTL and testbench
=================================

Name: updown_counter

Overview:
- Parameterized registered up/down counter.
- Each clock it adds an unsigned increment amount and subtracts an unsigned decrement amount, modulo 2^WIDTH by default.
- Generic utility block, e.g. for event or occupancy tracking in datapaths and control logic.
- Single clock domain; asynchronous active-low reset.

Parameters:
- WIDTH, 8, bit width of the count register (>=1).
- INC_SIZE, 1, bit width of the inc amount input (1..WIDTH).
- DEC_SIZE, 1, bit width of the dec amount input (1..WIDTH).
- SATURATE, 0, 0 = modular wrap-around; 1 = clamp at 0 and 2^WIDTH-1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- inc  input  INC_SIZE  unsigned amount added this cycle (0 = no increment).
- dec  input  DEC_SIZE  unsigned amount subtracted this cycle (0 = no decrement).
- count  output  WIDTH  registered counter value.

Interface decision: one clock (clk); reset rst_n is asynchronous and active-low.

Behaviour:
- Reset: rst_n low forces count to 0 immediately, independent of clk. count holds 0 while rst_n is low.
- Release: count stays 0 until the first rising clk edge with rst_n high.
- Reset mid-operation: the same asynchronous clear applies; the prior value is lost and counting restarts from 0.
- Update: on each rising clk edge with rst_n high, count <= f(count + inc - dec).
  - inc and dec are sampled at that edge.
  - Latency is 1 cycle: the result is visible right after the edge.
  - Hold: inc = 0 and dec = 0 keep count unchanged.
- Arithmetic:
  - Zero-extend count, inc and dec to WIDTH+2 bits and compute the signed sum s = count + inc - dec.
  - SATURATE=0: count <= s[WIDTH-1:0] (mod 2^WIDTH). All values 0..2^WIDTH-1 are reachable.
  - SATURATE=1: s < 0 gives 0; s > 2^WIDTH-1 gives 2^WIDTH-1; otherwise s.
- Simultaneous inc and dec: only the net (inc - dec) is applied in the same cycle; no priority between them.
- Wrap boundaries (SATURATE=0):
  - 2^WIDTH-1 plus 1 gives 0.
  - 0 minus 1 gives 2^WIDTH-1.
  - Multi-unit steps wrap modulo 2^WIDTH.
- No X propagation: the count register must never be uninitialised after reset.
- The output is a direct register output; no combinational path from inc or dec to count.
- Elaboration: error if INC_SIZE > WIDTH, DEC_SIZE > WIDTH, or WIDTH < 1.

Decomposition:
- Shared package: none required. Parameter-legality checks are local.
- Optional sub-module updown_counter_next: combinational next-value computation (extend, add/subtract, wrap or clamp). Reusable by other counters.
- The top level holds only the asynchronous-reset register.

Test Plan:
- Reset: rst_n=0 for 3 cycles, then release; toggle rst_n low mid-count at count=5 -> count is 0 immediately on assertion; counting restarts from 0 after release.
- Full-range increment: inc=1 for 255 consecutive edges from 0 (WIDTH=8) -> count=255. Then inc=0 for 5 edges -> count stays 255.
- Wrap up and down: from 255, inc=1 for one edge -> 0. Then dec=1 for one edge -> 255. Then dec=1 for 255 edges -> 0.
- Simultaneous: inc=1 and dec=1 together for 10 edges at count=42 -> count stays 42. With INC_SIZE=DEC_SIZE=4, inc=7, dec=3 from 0 -> 4, 8, 12 on successive edges.
- Saturation (SATURATE=1): from 250, inc=15 (INC_SIZE=4) -> 255. From 2, dec=5 -> 0. Both are held on further identical stimulus.
- Random: random inc/dec for 10k cycles with random async reset pulses -> count matches a reference model (mod 2^WIDTH) every cycle.

Source files
------------

// File: rtl/updown_counter_pkg.sv
// rtl/updown_counter_pkg.sv - shared constants and types for the up/down counter slice
package updown_counter_pkg;

    // Two guard bits hold count + inc - dec without loss: one for carry, one for sign.
    localparam int EXT_BITS = 2;

    typedef enum logic {
        MODE_WRAP  = 1'b0,
        MODE_CLAMP = 1'b1
    } count_mode_e;

    function automatic count_mode_e mode_from_param(input int saturate);
        return (saturate != 0) ? MODE_CLAMP : MODE_WRAP;
    endfunction

endpackage

// File: rtl/updown_counter_next.sv
// rtl/updown_counter_next.sv - combinational next-count: extend, add inc, subtract dec, wrap or clamp
module updown_counter_next
    import updown_counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int INC_SIZE = 1,
    parameter int DEC_SIZE = 1,
    parameter int SATURATE = 0
) (
    input  logic [WIDTH-1:0]    count,
    input  logic [INC_SIZE-1:0] inc,
    input  logic [DEC_SIZE-1:0] dec,
    output logic [WIDTH-1:0]    count_next
);

    if (WIDTH < 1) begin : g_bad_width
        $error("updown_counter_next: WIDTH must be >= 1");
    end
    if (INC_SIZE < 1 || INC_SIZE > WIDTH) begin : g_bad_inc
        $error("updown_counter_next: INC_SIZE must be in 1..WIDTH");
    end
    if (DEC_SIZE < 1 || DEC_SIZE > WIDTH) begin : g_bad_dec
        $error("updown_counter_next: DEC_SIZE must be in 1..WIDTH");
    end

    localparam int          EW   = WIDTH + EXT_BITS;
    localparam count_mode_e MODE = mode_from_param(SATURATE);

    logic [EW-1:0] count_ext;
    logic [EW-1:0] inc_ext;
    logic [EW-1:0] dec_ext;
    logic [EW-1:0] sum;
    logic          negative;
    logic          overflow;

    always_comb begin
        count_ext  = {{EXT_BITS{1'b0}}, count};
        inc_ext    = {{(EW-INC_SIZE){1'b0}}, inc};
        dec_ext    = {{(EW-DEC_SIZE){1'b0}}, dec};
        sum        = count_ext + inc_ext - dec_ext;
        // Top bit is the sign; a set bit WIDTH with a clear sign means above full scale.
        negative   = sum[EW-1];
        overflow   = ~sum[EW-1] & sum[WIDTH];
        count_next = sum[WIDTH-1:0];
        if (MODE == MODE_CLAMP) begin
            if (negative) begin
                count_next = '0;
            end else if (overflow) begin
                count_next = '1;
            end
        end
    end

endmodule

// File: rtl/updown_counter.sv
// rtl/updown_counter.sv - registered up/down counter with asynchronous active-low clear
module updown_counter
    import updown_counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int INC_SIZE = 1,
    parameter int DEC_SIZE = 1,
    parameter int SATURATE = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [INC_SIZE-1:0] inc,
    input  logic [DEC_SIZE-1:0] dec,
    output logic [WIDTH-1:0]    count
);

    logic [WIDTH-1:0] count_next;

    updown_counter_next #(
        .WIDTH    (WIDTH),
        .INC_SIZE (INC_SIZE),
        .DEC_SIZE (DEC_SIZE),
        .SATURATE (SATURATE)
    ) u_next (
        .count      (count),
        .inc        (inc),
        .dec        (dec),
        .count_next (count_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: tb/tb_updown_counter.sv
// tb/tb_updown_counter.sv - self-checking bench for updown_counter in wrap and clamp configurations
module tb_updown_counter;

    logic       clk;
    logic       rst_n;
    logic       inc_a;
    logic       dec_a;
    logic [3:0] inc_b;
    logic [3:0] dec_b;
    logic [3:0] inc_c;
    logic [3:0] dec_c;
    logic [7:0] count_a;
    logic [7:0] count_b;
    logic [7:0] count_c;

    int n_cmp  = 0;
    int n_fail = 0;

    updown_counter #(.WIDTH(8), .INC_SIZE(1), .DEC_SIZE(1), .SATURATE(0)) u_a (
        .clk(clk), .rst_n(rst_n), .inc(inc_a), .dec(dec_a), .count(count_a)
    );
    updown_counter #(.WIDTH(8), .INC_SIZE(4), .DEC_SIZE(4), .SATURATE(0)) u_b (
        .clk(clk), .rst_n(rst_n), .inc(inc_b), .dec(dec_b), .count(count_b)
    );
    updown_counter #(.WIDTH(8), .INC_SIZE(4), .DEC_SIZE(4), .SATURATE(1)) u_c (
        .clk(clk), .rst_n(rst_n), .inc(inc_c), .dec(dec_c), .count(count_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] inc;
        logic [3:0] dec;
        logic [7:0] exp_wrap;
        logic [7:0] exp_sat;
    } vec_t;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] model_wrap(input int c, input int i, input int d);
        int s;
        s = c + i - d;
        while (s < 0) s += 256;
        return 8'(s % 256);
    endfunction

    function automatic logic [7:0] model_sat(input int c, input int i, input int d);
        int s;
        s = c + i - d;
        if (s < 0) return 8'd0;
        if (s > 255) return 8'd255;
        return 8'(s);
    endfunction

    vec_t vecs[12];
    logic [7:0] m_a, m_b, m_c;

    initial begin
        vecs[0]  = '{4'd7,  4'd3,  8'd4,   8'd4};
        vecs[1]  = '{4'd7,  4'd3,  8'd8,   8'd8};
        vecs[2]  = '{4'd7,  4'd3,  8'd12,  8'd12};
        vecs[3]  = '{4'd0,  4'd0,  8'd12,  8'd12};
        vecs[4]  = '{4'd0,  4'd15, 8'd253, 8'd0};
        vecs[5]  = '{4'd0,  4'd0,  8'd253, 8'd0};
        vecs[6]  = '{4'd15, 4'd0,  8'd12,  8'd15};
        vecs[7]  = '{4'd15, 4'd15, 8'd12,  8'd15};
        vecs[8]  = '{4'd3,  4'd15, 8'd0,   8'd3};
        vecs[9]  = '{4'd0,  4'd1,  8'd255, 8'd2};
        vecs[10] = '{4'd0,  4'd5,  8'd250, 8'd0};
        vecs[11] = '{4'd0,  4'd5,  8'd245, 8'd0};

        rst_n = 1'b0;
        inc_a = 1'b0; dec_a = 1'b0;
        inc_b = '0;   dec_b = '0;
        inc_c = '0;   dec_c = '0;
        #1;
        check("reset_a", count_a, 8'd0);
        check("reset_b", count_b, 8'd0);
        check("reset_c", count_c, 8'd0);

        inc_a = 1'b1;
        repeat (3) begin
            tick;
            check("reset_hold_a", count_a, 8'd0);
        end
        rst_n = 1'b1;
        #2;
        check("release_a", count_a, 8'd0);

        repeat (5) tick;
        check("count5_a", count_a, 8'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clear_a", count_a, 8'd0);
        tick;
        check("clear_hold_a", count_a, 8'd0);
        rst_n = 1'b1;
        tick;
        check("restart1_a", count_a, 8'd1);
        tick;
        check("restart2_a", count_a, 8'd2);

        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        repeat (255) tick;
        check("full_range_a", count_a, 8'd255);
        inc_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            check("hold255_a", count_a, 8'd255);
        end
        inc_a = 1'b1;
        tick;
        check("wrap_up_a", count_a, 8'd0);
        inc_a = 1'b0; dec_a = 1'b1;
        tick;
        check("wrap_down_a", count_a, 8'd255);
        repeat (255) tick;
        check("down_to_zero_a", count_a, 8'd0);
        dec_a = 1'b0; inc_a = 1'b1;
        repeat (42) tick;
        check("count42_a", count_a, 8'd42);
        dec_a = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick;
            check("simul42_a", count_a, 8'd42);
        end
        inc_a = 1'b0; dec_a = 1'b0;

        for (int i = 0; i < 12; i++) begin
            inc_b = vecs[i].inc; dec_b = vecs[i].dec;
            inc_c = vecs[i].inc; dec_c = vecs[i].dec;
            tick;
            check($sformatf("vec%0d_wrap", i), count_b, vecs[i].exp_wrap);
            check($sformatf("vec%0d_sat", i), count_c, vecs[i].exp_sat);
        end

        // Climb the clamping counter to 250, then push past full scale.
        inc_b = 4'd15; dec_b = 4'd0;
        inc_c = 4'd15; dec_c = 4'd0;
        repeat (16) tick;
        check("climb240_sat", count_c, 8'd240);
        inc_b = 4'd10; inc_c = 4'd10;
        tick;
        check("at250_sat", count_c, 8'd250);
        check("at250_wrap", count_b, 8'd239);
        inc_b = 4'd15; inc_c = 4'd15;
        tick;
        check("clamp_hi_sat", count_c, 8'd255);
        check("clamp_hi_wrap", count_b, 8'd254);
        tick;
        check("clamp_hi_hold_sat", count_c, 8'd255);
        check("wrap_multi_wrap", count_b, 8'd13);

        m_a = count_a; m_b = 8'd13; m_c = 8'd255;
        for (int i = 0; i < 10000; i++) begin
            inc_a = 1'($urandom_range(0, 1));
            dec_a = 1'($urandom_range(0, 1));
            inc_b = 4'($urandom_range(0, 15));
            dec_b = 4'($urandom_range(0, 15));
            inc_c = 4'($urandom_range(0, 15));
            dec_c = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                #1;
                m_a = '0; m_b = '0; m_c = '0;
                check("rand_rst_a", count_a, m_a);
                check("rand_rst_b", count_b, m_b);
                check("rand_rst_c", count_c, m_c);
                #1;
                rst_n = 1'b1;
            end
            tick;
            m_a = model_wrap(int'(m_a), int'(inc_a), int'(dec_a));
            m_b = model_wrap(int'(m_b), int'(inc_b), int'(dec_b));
            m_c = model_sat(int'(m_c), int'(inc_c), int'(dec_c));
            check("rand_a", count_a, m_a);
            check("rand_b", count_b, m_b);
            check("rand_c", count_c, m_c);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
